// File: rtl/fp_align_stage_if.sv
// Operand-in / aligned-out handshake bundle for the FP add/sub
// alignment stage.
interface fp_align_stage_if;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        Op;
  logic        Out_valid;
  logic        Out_ready;
  logic [7:0]  Exp_large;
  logic [26:0] Mant_large;
  logic [26:0] Mant_small;
  logic        Sign_large;
  logic        Eff_sub;
  logic        Swap;

  modport slave (
    input  In_valid,
    input  A,
    input  B,
    input  Op,
    input  Out_ready,
    output In_ready,
    output Out_valid,
    output Exp_large,
    output Mant_large,
    output Mant_small,
    output Sign_large,
    output Eff_sub,
    output Swap
  );

  modport master (
    output In_valid,
    output A,
    output B,
    output Op,
    output Out_ready,
    input  In_ready,
    input  Out_valid,
    input  Exp_large,
    input  Mant_large,
    input  Mant_small,
    input  Sign_large,
    input  Eff_sub,
    input  Swap
  );
endinterface

// File: rtl/fp_align_stage.sv
// FP add/sub exponent alignment: S1 unpack/compare, S2 shift.
// Two-entry elastic pipeline with combinational ready.
module fp_align_stage (
  input logic          clk,
  input logic          rst_n,
  fp_align_stage_if.slave bus
);

  typedef struct packed {
    logic [7:0]  exp_l;
    logic [23:0] mant_l;
    logic [23:0] mant_s;
    logic [7:0]  shamt;
    logic        sign_l;
    logic        eff_sub;
    logic        swap;
  } s1_t;

  typedef struct packed {
    logic [7:0]  exp_l;
    logic [26:0] mant_l;
    logic [26:0] mant_s;
    logic        sign_l;
    logic        eff_sub;
    logic        swap;
  } s2_t;

  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  s1_t  s1_q, s1_d, s1_new;
  s2_t  s2_q, s2_d, s2_new;

  logic accept;
  logic consume;
  logic s1_adv;

  logic [7:0]  exp_a, exp_b;
  logic [23:0] man_a, man_b;
  logic        sgn_a, sgn_b;
  logic        swap;

  // Right shift with sticky collection of everything shifted out.
  function automatic logic [26:0] align(
    input logic [23:0] m,
    input logic [7:0]  sh
  );
    logic [26:0] full;
    logic [26:0] mask;
    logic [26:0] res;
    logic [4:0]  s5;
    full = {m, 3'b000};
    s5   = sh[4:0];
    mask = ~(27'h7FF_FFFF << s5);
    if (sh >= 8'd27) begin
      res = {26'd0, |m};
    end else begin
      res = (full >> s5)
          | {26'd0, |(full & mask)};
    end
    return res;
  endfunction

  assign consume = s2_vld_q & bus.Out_ready;
  assign s1_adv  = s1_vld_q
                 & (~s2_vld_q | consume);
  assign bus.In_ready = ~s1_vld_q | s1_adv;
  assign accept  = bus.In_valid & bus.In_ready;

  always_comb begin
    exp_a = bus.A[30:23];
    exp_b = bus.B[30:23];
    if (exp_a == 8'd0) exp_a = 8'd1;
    if (exp_b == 8'd0) exp_b = 8'd1;
    man_a = {|bus.A[30:23], bus.A[22:0]};
    man_b = {|bus.B[30:23], bus.B[22:0]};
    sgn_a = bus.A[31];
    sgn_b = bus.B[31] ^ bus.Op;
    swap  = (exp_b > exp_a)
          | ((exp_b == exp_a)
             & (man_b > man_a));
  end

  always_comb begin
    s1_new = '0;
    s1_new.swap    = swap;
    s1_new.eff_sub = sgn_a ^ sgn_b;
    unique case (1'b1)
      swap: begin
        s1_new.exp_l  = exp_b;
        s1_new.mant_l = man_b;
        s1_new.mant_s = man_a;
        s1_new.shamt  = exp_b - exp_a;
        s1_new.sign_l = sgn_b;
      end
      default: begin
        s1_new.exp_l  = exp_a;
        s1_new.mant_l = man_a;
        s1_new.mant_s = man_b;
        s1_new.shamt  = exp_a - exp_b;
        s1_new.sign_l = sgn_a;
      end
    endcase
  end

  always_comb begin
    s2_new         = '0;
    s2_new.exp_l   = s1_q.exp_l;
    s2_new.mant_l  = {s1_q.mant_l, 3'b000};
    s2_new.mant_s  = align(s1_q.mant_s,
                           s1_q.shamt);
    s2_new.sign_l  = s1_q.sign_l;
    s2_new.eff_sub = s1_q.eff_sub;
    s2_new.swap    = s1_q.swap;
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_d     = s1_q;
    s2_vld_d = s2_vld_q;
    s2_d     = s2_q;
    if (s1_adv) begin
      s2_vld_d = 1'b1;
      s2_d     = s2_new;
    end else if (consume) begin
      s2_vld_d = 1'b0;
    end
    if (accept) begin
      s1_vld_d = 1'b1;
      s1_d     = s1_new;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign bus.Out_valid  = s2_vld_q;
  assign bus.Exp_large  = s2_q.exp_l;
  assign bus.Mant_large = s2_q.mant_l;
  assign bus.Mant_small = s2_q.mant_s;
  assign bus.Sign_large = s2_q.sign_l;
  assign bus.Eff_sub    = s2_q.eff_sub;
  assign bus.Swap       = s2_q.swap;

endmodule
